// File: rtl/fp_add_sub_pipe.sv
// ---------------------------------------------------------------------------
// fp_add_sub_pipe
//   Pipelined floating-point adder/subtractor for an IEEE-754-style format
//   {sign, EXP_W exponent, MAN_W fraction}. Round-to-nearest-even, subnormal
//   inputs and results flushed to zero, canonical quiet NaN on invalid input.
//
//   The operand pair is registered on accept. Three compute stages follow:
//     S1 unpack / classify / compare / align
//     S2 add or subtract the aligned significands
//     S3 normalise / round / pack
//   The S3 result lands in the output register, so a result appears three
//   edges after its operands were accepted. One global advance signal moves
//   every stage at once; it is low only while the output is held.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   operand pair present on x/y/op
//   in_ready   block accepts operands this cycle
//   op         0 = x + y, 1 = x - y
//   x, y       operands, W = 1 + EXP_W + MAN_W bits
//   out_valid  result present on z/flags
//   out_ready  downstream accepts the result
//   z          rounded result
//   flags      {invalid, overflow, underflow, inexact}, qualified by out_valid
// ---------------------------------------------------------------------------
module fp_add_sub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic [3:0]   flags
);

  // Significand with hidden bit plus guard, round and sticky positions.
  localparam int SIG_W   = MAN_W + 4;
  // One extra bit for the carry out of a magnitude add.
  localparam int SUM_W   = MAN_W + 5;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         op;
  } opnd_t;

  typedef struct packed {
    logic             special;        // result fully decided in S1
    logic [W-1:0]     special_z;
    logic [3:0]       special_flags;
    logic             sign;           // sign of the larger magnitude
    logic [EXP_W-1:0] exp;            // exponent of the larger magnitude
    logic             eff_sub;
    logic [SIG_W-1:0] sig_l;
    logic [SIG_W-1:0] sig_s;          // aligned, sticky folded into bit 0
  } align_t;

  typedef struct packed {
    logic             special;
    logic [W-1:0]     special_z;
    logic [3:0]       special_flags;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SUM_W-1:0] sum;
  } sum_t;

  // Pipeline control
  logic   advance;
  logic   s1_valid_q, s1_valid_d;
  logic   s2_valid_q, s2_valid_d;
  logic   s3_valid_q, s3_valid_d;
  logic   out_valid_q, out_valid_d;

  // Pipeline payload
  opnd_t  s1_q, s1_d;
  align_t s2_q, s2_d;
  sum_t   s3_q, s3_d;
  logic [W-1:0] z_q, z_d;
  logic [3:0]   flags_q, flags_d;

  // The whole pipe moves together; it freezes only while a result is held.
  assign advance   = !(out_valid_q && !out_ready);
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign flags     = flags_q;

  // -------------------------------------------------------------------------
  // Valid chain
  // -------------------------------------------------------------------------
  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    s3_valid_d  = s3_valid_q;
    out_valid_d = out_valid_q;
    if (advance) begin
      s1_valid_d  = in_valid;
      s2_valid_d  = s1_valid_q;
      s3_valid_d  = s2_valid_q;
      out_valid_d = s3_valid_q;
    end
  end

  // -------------------------------------------------------------------------
  // S1: unpack, classify, compare, align
  // -------------------------------------------------------------------------
  logic             x_s, y_s;
  logic [EXP_W-1:0] x_e, y_e;
  logic [MAN_W-1:0] x_f, y_f;
  logic             x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, x_snan, y_snan;
  logic             x_ge;
  logic [EXP_W-1:0] exp_diff;
  logic [SIG_W-1:0] sig_small, lost_mask;

  assign x_s = s1_q.x[W-1];
  assign x_e = s1_q.x[W-2 -: EXP_W];
  assign x_f = s1_q.x[MAN_W-1:0];
  // Subtraction is folded into the sign of y up front.
  assign y_s = s1_q.y[W-1] ^ s1_q.op;
  assign y_e = s1_q.y[W-2 -: EXP_W];
  assign y_f = s1_q.y[MAN_W-1:0];

  // A zero exponent means zero or subnormal; both are treated as signed zero.
  assign x_zero = (x_e == '0);
  assign y_zero = (y_e == '0);
  assign x_inf  = (x_e == EXP_ONES) && (x_f == '0);
  assign y_inf  = (y_e == EXP_ONES) && (y_f == '0);
  assign x_nan  = (x_e == EXP_ONES) && (x_f != '0);
  assign y_nan  = (y_e == EXP_ONES) && (y_f != '0);
  assign x_snan = x_nan && !x_f[MAN_W-1];
  assign y_snan = y_nan && !y_f[MAN_W-1];
  assign x_ge   = {x_e, x_f} >= {y_e, y_f};

  always_comb begin
    s1_d      = '{x: x, y: y, op: op};
    s2_d      = '0;
    exp_diff  = '0;
    sig_small = '0;
    lost_mask = '0;

    s2_d.eff_sub = x_s ^ y_s;
    if (x_ge) begin
      s2_d.sign  = x_s;
      s2_d.exp   = x_e;
      s2_d.sig_l = {1'b1, x_f, 3'b000};
      sig_small  = {1'b1, y_f, 3'b000};
      exp_diff   = x_e - y_e;
    end else begin
      s2_d.sign  = y_s;
      s2_d.exp   = y_e;
      s2_d.sig_l = {1'b1, y_f, 3'b000};
      sig_small  = {1'b1, x_f, 3'b000};
      exp_diff   = y_e - x_e;
    end

    if (int'(exp_diff) >= MAN_W + 3) begin
      // Entirely below the round position: only its presence matters.
      s2_d.sig_s = {{(SIG_W-1){1'b0}}, 1'b1};
    end else begin
      lost_mask  = ~({SIG_W{1'b1}} << exp_diff);
      s2_d.sig_s = (sig_small >> exp_diff) |
                   {{(SIG_W-1){1'b0}}, |(sig_small & lost_mask)};
    end

    // Results that bypass the arithmetic path, in priority order.
    if (x_nan || y_nan) begin
      s2_d.special       = 1'b1;
      s2_d.special_z     = QNAN;
      s2_d.special_flags = {x_snan || y_snan, 3'b000};
    end else if (x_inf && y_inf && s2_d.eff_sub) begin
      s2_d.special       = 1'b1;
      s2_d.special_z     = QNAN;
      s2_d.special_flags = 4'b1000;
    end else if (x_inf) begin
      s2_d.special   = 1'b1;
      s2_d.special_z = {x_s, EXP_ONES, {MAN_W{1'b0}}};
    end else if (y_inf) begin
      s2_d.special   = 1'b1;
      s2_d.special_z = {y_s, EXP_ONES, {MAN_W{1'b0}}};
    end else if (x_zero && y_zero) begin
      // Only (-0) + (-0) keeps a negative sign under round-to-nearest.
      s2_d.special   = 1'b1;
      s2_d.special_z = {x_s && y_s, {(W-1){1'b0}}};
    end else if (x_zero) begin
      s2_d.special   = 1'b1;
      s2_d.special_z = {y_s, y_e, y_f};
    end else if (y_zero) begin
      s2_d.special   = 1'b1;
      s2_d.special_z = {x_s, x_e, x_f};
    end
  end

  // -------------------------------------------------------------------------
  // S2: magnitude add or subtract (sig_l >= sig_s, so never negative)
  // -------------------------------------------------------------------------
  always_comb begin
    s3_d.special       = s2_q.special;
    s3_d.special_z     = s2_q.special_z;
    s3_d.special_flags = s2_q.special_flags;
    s3_d.sign          = s2_q.sign;
    s3_d.exp           = s2_q.exp;
    if (s2_q.eff_sub) s3_d.sum = {1'b0, s2_q.sig_l} - {1'b0, s2_q.sig_s};
    else              s3_d.sum = {1'b0, s2_q.sig_l} + {1'b0, s2_q.sig_s};
  end

  // -------------------------------------------------------------------------
  // S3: normalise, round to nearest even, pack
  // -------------------------------------------------------------------------
  int               msb, shamt, exp_n;
  logic [SIG_W-1:0] norm;
  logic             round_up, inexact;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac_r;

  always_comb begin
    z_d      = '0;
    flags_d  = '0;
    msb      = 0;
    shamt    = 0;
    exp_n    = 0;
    norm     = '0;
    round_up = 1'b0;
    inexact  = 1'b0;
    mant_r   = '0;
    frac_r   = '0;

    for (int i = 0; i < SIG_W; i++) begin
      if (s3_q.sum[i]) msb = i;
    end

    if (s3_q.sum[SUM_W-1]) begin
      // Carry out: shift right one, keeping the dropped bit as sticky.
      norm  = {s3_q.sum[SUM_W-1:2], |s3_q.sum[1:0]};
      exp_n = int'(s3_q.exp) + 1;
    end else begin
      shamt = (SIG_W - 1) - msb;
      norm  = s3_q.sum[SIG_W-1:0] << shamt;
      exp_n = int'(s3_q.exp) - shamt;
    end

    inexact  = |norm[2:0];
    round_up = norm[2] && (norm[1] || norm[0] || norm[3]);
    mant_r   = {1'b0, norm[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
    if (mant_r[MAN_W+1]) begin
      exp_n  = exp_n + 1;
      frac_r = mant_r[MAN_W:1];
    end else begin
      frac_r = mant_r[MAN_W-1:0];
    end

    if (s3_q.special) begin
      z_d     = s3_q.special_z;
      flags_d = s3_q.special_flags;
    end else if (s3_q.sum == '0) begin
      z_d = '0;                                  // exact cancellation is +0
    end else if (exp_n >= EXP_MAX) begin
      z_d     = {s3_q.sign, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (exp_n <= 0) begin
      z_d     = {s3_q.sign, {(W-1){1'b0}}};      // too small: flush to zero
      flags_d = 4'b0011;
    end else begin
      z_d     = {s3_q.sign, EXP_W'(exp_n), frac_r};
      flags_d = {3'b000, inexact};
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: state is written with non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      out_valid_q <= out_valid_d;
      if (advance) begin
        z_q     <= z_d;
        flags_q <= flags_d;
      end
    end
  end

  // NOTE: the stage payload has no reset; it is meaningless until its valid
  // bit is set, and the valid bits are reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

endmodule

// File: doc/fp_add_sub_pipe.md
FP_ADD_SUB_PIPE -- requirements
Module: fp_add_sub_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width (range 4..11).
REQ-002 Parameter MAN_W, default 23, stored fraction width (range 4..52); word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 op  input  1  0 = x+y, 1 = x-y.
REQ-008 x  input  W  operand A, IEEE-754-style layout {sign, exponent, fraction}.
REQ-009 y  input  W  operand B, same layout.
REQ-010 out_valid  output  1  result present on z/flags.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 z  output  W  rounded result.
REQ-013 flags  output  4  {invalid, overflow, underflow, inexact}, qualified by out_valid.

Function
REQ-014 Three-stage pipeline: S1 unpack/compare/align, S2 add-or-subtract significands, S3 normalise/round/pack; each stage holds a valid bit.
REQ-015 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-016 in_ready = !(out_valid && !out_ready); on stall all stages hold contents and z/flags stay stable.
REQ-017 No stall: result for an operand accepted at edge N is presented with out_valid high after edge N+3; throughput one result per cycle.
REQ-018 Effective operation: sign_y' = y.sign XOR op; same signs -> magnitude add, differing signs -> magnitude subtract.
REQ-019 Larger-magnitude operand (exponent, then fraction) sets result sign; smaller one right-shifted by exponent difference, shifted-out bits collected into guard, round, sticky.
REQ-020 Exponent difference >= MAN_W+3 -> smaller operand contributes only sticky.
REQ-021 Subnormal inputs (exp = 0, frac != 0) flushed to signed zero before use; subnormal results flushed to zero with underflow=1, inexact=1.
REQ-022 Rounding: round-to-nearest, ties-to-even; mantissa carry-out increments exponent.
REQ-023 Exact cancellation (equal magnitudes, effective subtract) -> +0, no flags; (-0)+(-0) -> -0.
REQ-024 Rounded exponent >= all-ones -> signed infinity, overflow=1, inexact=1.
REQ-025 Any NaN input, or Inf minus Inf (effective subtract) -> canonical quiet NaN {0, all-ones, 1 followed by zeros}; invalid=1 only for Inf-Inf or signalling NaN (fraction MSB 0).
REQ-026 Inf with finite operand -> that Inf, no flags.
REQ-027 inexact=1 whenever guard|round|sticky nonzero after normalisation.
REQ-028 Zero operand -> other operand returned unchanged (after sign_y' applied).

Reset
REQ-029 reset low: all stage valid bits, out_valid, z, flags -> 0 immediately; in_ready -> 1.
REQ-030 Reset mid-operation discards every in-flight operand; no result emitted for it after release.
REQ-031 First transfer possible on the first rising edge with reset high.

Verification
REQ-032 x=0x3F800000, y=0x40000000, op=0 -> z=0x40400000, flags=0000, out_valid 3 cycles after accept.
REQ-033 x=0x40400000, y=0x40400000, op=1 -> z=0x00000000, flags=0000.
REQ-034 x=0x3F800000, y=0x33800000, op=0 (tie) -> z=0x3F800000, flags=0001; y=0x33800001 -> z=0x3F800001, flags=0001.
REQ-035 x=0x7F7FFFFF, y=0x7F7FFFFF, op=0 -> z=0x7F800000, flags=0101; x=0x7F800000, y=0x7F800000, op=1 -> z=0x7FC00000, flags=1000.
REQ-036 Stream 6 back-to-back pairs, hold out_ready low 4 cycles mid-stream -> in_ready low while stalled, all 6 results in order, none lost or duplicated, z stable during stall.
REQ-037 Pulse reset low with 3 operands in flight -> out_valid 0 during and after reset, no stale results; next operand yields correct result at latency 3.
